// File: rtl/rx_threshold_calibrator.sv
// Sweeps every sense-amp threshold code, counts rx_bit errors against the reference
// stream at each one, then drives the centre of the widest error-free code window.
module rx_threshold_calibrator #(
  parameter int CODE_W        = 4,
  parameter int PRESET_CODE   = 5,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW        = 256,
  parameter int ERR_W         = 9,
  parameter int MAX_ERR       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic              rx_bit,
  input  logic              ref_bit,
  output logic [CODE_W-1:0] threshold_code,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CODE_W-1:0] win_lo,
  output logic [CODE_W-1:0] win_hi
);

  localparam int SMP_W = $clog2(WINDOW + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_EVAL    = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  localparam logic [CODE_W-1:0] CODE_LAST   = {CODE_W{1'b1}};
  localparam logic [CODE_W-1:0] CODE_PRESET = CODE_W'(PRESET_CODE);
  localparam logic [ERR_W-1:0]  ERR_SAT     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_LIMIT   = ERR_W'(MAX_ERR);
  localparam logic [SMP_W-1:0]  SMP_LAST    = SMP_W'(WINDOW - 1);
  localparam logic [SET_W-1:0]  SET_LAST    = SET_W'(SETTLE_CYCLES - 1);

  logic [2:0]        state_r;
  logic [CODE_W-1:0] code_r;
  logic              busy_r;
  logic              done_r;
  logic              fail_r;
  logic [CODE_W-1:0] win_lo_r;
  logic [CODE_W-1:0] win_hi_r;
  logic [SET_W-1:0]  settle_cnt_r;
  logic [SMP_W-1:0]  smp_r;
  logic [ERR_W-1:0]  err_r;
  logic [CODE_W:0]   cur_len_r;
  logic [CODE_W-1:0] cur_start_r;
  logic [CODE_W:0]   best_len_r;
  logic [CODE_W-1:0] best_start_r;

  logic              pass_s;
  logic [CODE_W:0]   cur_len_nxt_s;
  logic [CODE_W-1:0] cur_start_nxt_s;
  logic [CODE_W-1:0] win_hi_nxt_s;
  logic [CODE_W-1:0] centre_s;

  // Run tracking for the code under evaluation and the final window arithmetic.
  // best_len of 2^CODE_W truncates to zero in the low bits; the wrap of -1 still gives the top code.
  always_comb begin
    pass_s          = (err_r <= ERR_LIMIT);
    cur_len_nxt_s   = {(CODE_W+1){1'b0}};
    cur_start_nxt_s = cur_start_r;
    if (pass_s) begin
      cur_len_nxt_s = cur_len_r + (CODE_W+1)'(1);
      if (cur_len_r == {(CODE_W+1){1'b0}}) begin
        cur_start_nxt_s = code_r;
      end else begin
        cur_start_nxt_s = cur_start_r;
      end
    end else begin
      cur_len_nxt_s   = {(CODE_W+1){1'b0}};
      cur_start_nxt_s = cur_start_r;
    end
    win_hi_nxt_s = best_start_r + best_len_r[CODE_W-1:0] - CODE_W'(1);
    centre_s     = best_start_r + ((win_hi_nxt_s - best_start_r) >> 1);
  end

  // Sweep sequencer: settle, measure, evaluate each code in turn, then publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      code_r       <= CODE_PRESET;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fail_r       <= 1'b0;
      win_lo_r     <= {CODE_W{1'b0}};
      win_hi_r     <= {CODE_W{1'b0}};
      settle_cnt_r <= {SET_W{1'b0}};
      smp_r        <= {SMP_W{1'b0}};
      err_r        <= {ERR_W{1'b0}};
      cur_len_r    <= {(CODE_W+1){1'b0}};
      cur_start_r  <= {CODE_W{1'b0}};
      best_len_r   <= {(CODE_W+1){1'b0}};
      best_start_r <= {CODE_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_SETTLE;
            code_r       <= {CODE_W{1'b0}};
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            fail_r       <= 1'b0;
            settle_cnt_r <= {SET_W{1'b0}};
            smp_r        <= {SMP_W{1'b0}};
            err_r        <= {ERR_W{1'b0}};
            cur_len_r    <= {(CODE_W+1){1'b0}};
            cur_start_r  <= {CODE_W{1'b0}};
            best_len_r   <= {(CODE_W+1){1'b0}};
            best_start_r <= {CODE_W{1'b0}};
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SET_LAST) begin
            state_r <= ST_MEASURE;
            smp_r   <= {SMP_W{1'b0}};
            err_r   <= {ERR_W{1'b0}};
          end else begin
            settle_cnt_r <= settle_cnt_r + SET_W'(1);
          end
        end
        ST_MEASURE: begin
          if (rx_valid) begin
            smp_r <= smp_r + SMP_W'(1);
            if ((rx_bit != ref_bit) && (err_r != ERR_SAT)) begin
              err_r <= err_r + ERR_W'(1);
            end
            if (smp_r == SMP_LAST) begin
              state_r <= ST_EVAL;
            end
          end
        end
        ST_EVAL: begin
          cur_len_r   <= cur_len_nxt_s;
          cur_start_r <= cur_start_nxt_s;
          // Strictly greater: a tie keeps the earlier, lower run.
          if (cur_len_nxt_s > best_len_r) begin
            best_len_r   <= cur_len_nxt_s;
            best_start_r <= cur_start_nxt_s;
          end
          if (code_r == CODE_LAST) begin
            state_r <= ST_FINISH;
          end else begin
            code_r       <= code_r + CODE_W'(1);
            settle_cnt_r <= {SET_W{1'b0}};
            state_r      <= ST_SETTLE;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          if (best_len_r == {(CODE_W+1){1'b0}}) begin
            fail_r <= 1'b1;
            code_r <= CODE_PRESET;
          end else begin
            win_lo_r <= best_start_r;
            win_hi_r <= win_hi_nxt_s;
            code_r   <= centre_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          code_r  <= CODE_PRESET;
        end
      endcase
    end
  end

  assign threshold_code = code_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign fail           = fail_r;
  assign win_lo         = win_lo_r;
  assign win_hi         = win_hi_r;

endmodule
